// File: rtl/mux_41_scan_ctrl.sv
// Scan sequencer for a 4:1 bit mux: captures a word, sweeps sel 0..3 with a programmable dwell,
// samples f per channel, and streams/reassembles the bits. Optional parity: `MUX_SCAN_PARITY_EN.
module mux_41_scan_ctrl #(
  parameter int unsigned DWELL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] i,
  output logic [3:0] i_hold,
  output logic [1:0] sel,
  input  logic       f,
  output logic       bit_out,
  output logic       bit_valid,
  output logic [3:0] word_out,
  output logic       busy,
  output logic       done,
  output logic       parity_out
);

  // state  | meaning
  // IDLE   | waiting for start; captured word and results held
  // SCAN   | dwelling on channel sel, sampling f at the end of each dwell
  // DONE   | one-cycle completion, done asserted
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] i_hold_q, i_hold_d;
  logic [3:0] word_q, word_d;
  logic       bit_out_q, bit_out_d;
  logic       bit_valid_q, bit_valid_d;
  logic       last_cnt;

`ifdef MUX_SCAN_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign last_cnt = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      sel_q       <= 2'd0;
      i_hold_q    <= 4'd0;
      word_q      <= 4'd0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      i_hold_q    <= i_hold_d;
      word_q      <= word_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    i_hold_d    = i_hold_q;
    word_d      = word_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SCAN;
          i_hold_d = i;
          sel_d    = 2'd0;
          cnt_d    = 8'd0;
        end
      end
      S_SCAN: begin
        if (last_cnt) begin
          word_d[sel_q] = f;
          bit_out_d     = f;
          bit_valid_d   = 1'b1;
          cnt_d         = 8'd0;
          if (sel_q == 2'd3) begin
            // sel parks on 3 through DONE; it returns to 0 on the way back to IDLE
            state_d = S_DONE;
`ifdef MUX_SCAN_PARITY_EN
            parity_d = ^word_d;
`endif
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        sel_d   = 2'd0;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = 2'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    i_hold    = i_hold_q;
    sel       = sel_q;
    bit_out   = bit_out_q;
    bit_valid = bit_valid_q;
    word_out  = word_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
`ifdef MUX_SCAN_PARITY_EN
    parity_out = parity_q;
`else
    parity_out = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mux_41_scan_ctrl.sv
// Directed bench for mux_41_scan_ctrl: two instances (DWELL=1 and DWELL=3), each closed
// through a zero-latency 4:1 mux model on f.
module tb_mux_41_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic [3:0] i1 = 4'd0, i3 = 4'd0;

  logic [3:0] i_hold1, i_hold3, word1, word3;
  logic [1:0] sel1, sel3;
  logic       f1, f3;
  logic       bit_out1, bit_out3, bit_valid1, bit_valid3;
  logic       busy1, busy3, done1, done3, parity1, parity3;

  int checks = 0;
  int passed = 0;

`ifdef MUX_SCAN_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  assign f1 = i_hold1[sel1];
  assign f3 = i_hold3[sel3];

  mux_41_scan_ctrl #(.DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .i(i1), .i_hold(i_hold1), .sel(sel1), .f(f1),
    .bit_out(bit_out1), .bit_valid(bit_valid1), .word_out(word1), .busy(busy1),
    .done(done1), .parity_out(parity1)
  );

  mux_41_scan_ctrl #(.DWELL(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start3), .i(i3), .i_hold(i_hold3), .sel(sel3), .f(f3),
    .bit_out(bit_out3), .bit_valid(bit_valid3), .word_out(word3), .busy(busy3),
    .done(done3), .parity_out(parity3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({i_hold1, word1, bit_out1, bit_valid1, busy1, done1, parity1, sel1} !== 15'd0)
      $display("FAIL reset_d1: got %b want all zero",
               {i_hold1, word1, bit_out1, bit_valid1, busy1, done1, parity1, sel1});
    else passed++;
    checks++;
    if ({i_hold3, word3, bit_out3, bit_valid3, busy3, done3, parity3, sel3} !== 15'd0)
      $display("FAIL reset_d3: got %b want all zero",
               {i_hold3, word3, bit_out3, bit_valid3, busy3, done3, parity3, sel3});
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_scan();
    logic [3:0] w;
    logic [1:0] e_sel;
    w = 4'b1010;
    i1 = w;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n <= 5; n++) begin
      e_sel = (n < 4) ? 2'(n) : ((n == 4) ? 2'd3 : 2'd0);
      checks++;
      if (sel1 !== e_sel) $display("FAIL basic_sel n=%0d: got %0d want %0d", n, sel1, e_sel);
      else passed++;
      checks++;
      if (bit_valid1 !== (n >= 1 && n <= 4))
        $display("FAIL basic_bit_valid n=%0d: got %b want %b", n, bit_valid1, (n >= 1 && n <= 4));
      else passed++;
      checks++;
      if (done1 !== (n == 4)) $display("FAIL basic_done n=%0d: got %b want %b", n, done1, (n == 4));
      else passed++;
      checks++;
      if (busy1 !== (n <= 4)) $display("FAIL basic_busy n=%0d: got %b want %b", n, busy1, (n <= 4));
      else passed++;
      if (n >= 1 && n <= 4) begin
        checks++;
        if (bit_out1 !== w[n-1]) $display("FAIL basic_bit_out n=%0d: got %b want %b", n, bit_out1, w[n-1]);
        else passed++;
      end
      if (n < 5) tick();
    end
    checks++;
    if (word1 !== 4'b1010) $display("FAIL basic_word: got %b want 1010", word1);
    else passed++;
  endtask

  task automatic test_dwell_timing();
    logic [3:0] w;
    logic [1:0] e_sel;
    logic       e_bv;
    w = 4'b0110;
    i3 = w;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int n = 0; n <= 13; n++) begin
      e_sel = (n < 12) ? 2'(n / 3) : ((n == 12) ? 2'd3 : 2'd0);
      e_bv  = (n == 3 || n == 6 || n == 9 || n == 12);
      checks++;
      if (sel3 !== e_sel) $display("FAIL dwell_sel n=%0d: got %0d want %0d", n, sel3, e_sel);
      else passed++;
      checks++;
      if (bit_valid3 !== e_bv) $display("FAIL dwell_bit_valid n=%0d: got %b want %b", n, bit_valid3, e_bv);
      else passed++;
      checks++;
      if (done3 !== (n == 12)) $display("FAIL dwell_done n=%0d: got %b want %b", n, done3, (n == 12));
      else passed++;
      checks++;
      if (busy3 !== (n <= 12)) $display("FAIL dwell_busy n=%0d: got %b want %b", n, busy3, (n <= 12));
      else passed++;
      if (e_bv) begin
        checks++;
        if (bit_out3 !== w[n/3-1]) $display("FAIL dwell_bit_out n=%0d: got %b want %b", n, bit_out3, w[n/3-1]);
        else passed++;
      end
      if (n < 13) tick();
    end
    checks++;
    if (word3 !== 4'b0110) $display("FAIL dwell_word: got %b want 0110", word3);
    else passed++;
  endtask

  task automatic test_capture_isolation();
    i3 = 4'b1001;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    i3 = 4'b1111;
    for (int n = 0; n <= 14; n++) begin
      if (n == 12) begin
        checks++;
        if (done3 !== 1'b1) $display("FAIL iso_done: got %b want 1", done3);
        else passed++;
      end
      if (n >= 13) begin
        checks++;
        if (busy3 !== 1'b0) $display("FAIL iso_no_restart n=%0d: got busy %b want 0", n, busy3);
        else passed++;
      end
      start3 = (n == 2 || n == 12);
      tick();
    end
    checks++;
    if (word3 !== 4'b1001) $display("FAIL iso_word: got %b want 1001", word3);
    else passed++;
    checks++;
    if (i_hold3 !== 4'b1001) $display("FAIL iso_i_hold: got %b want 1001", i_hold3);
    else passed++;
  endtask

  task automatic test_reset_mid();
    i1 = 4'b0101;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    checks++;
    if (sel1 !== 2'd2) $display("FAIL rstmid_pre_sel: got %0d want 2", sel1);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({i_hold1, word1, bit_out1, bit_valid1, busy1, done1, parity1, sel1} !== 15'd0)
      $display("FAIL rstmid_outputs: got %b want all zero",
               {i_hold1, word1, bit_out1, bit_valid1, busy1, done1, parity1, sel1});
    else passed++;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if ({busy1, done1} !== 2'b00) $display("FAIL rstmid_no_done n=%0d: got busy,done %b want 00", n, {busy1, done1});
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    i1 = 4'b0001;
    start1 = 1'b1;
    tick();
    for (int n = 0; n <= 12; n++) begin
      if (n == 4) begin
        checks++;
        if ({done1, word1} !== 5'b1_0001) $display("FAIL b2b_first: got done,word %b want 10001", {done1, word1});
        else passed++;
        i1 = 4'b1000;
      end
      if (n == 5) begin
        checks++;
        if ({busy1, word1} !== 5'b0_0001) $display("FAIL b2b_gap: got busy,word %b want 00001", {busy1, word1});
        else passed++;
      end
      if (n == 6) begin
        checks++;
        if ({busy1, i_hold1} !== 5'b1_1000) $display("FAIL b2b_restart: got busy,i_hold %b want 11000", {busy1, i_hold1});
        else passed++;
      end
      if (n == 10) begin
        checks++;
        if ({done1, word1} !== 5'b1_1000) $display("FAIL b2b_second: got done,word %b want 11000", {done1, word1});
        else passed++;
        start1 = 1'b0;
      end
      if (n >= 11) begin
        checks++;
        if (busy1 !== 1'b0) $display("FAIL b2b_end n=%0d: got busy %b want 0", n, busy1);
        else passed++;
      end
      if (n < 12) tick();
    end
  endtask

  task automatic test_parity();
    i1 = 4'b0111;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    checks++;
    if ({done1, parity1} !== {1'b1, PAR_EN}) $display("FAIL parity_done: got done,parity %b want %b", {done1, parity1}, {1'b1, PAR_EN});
    else passed++;
    tick();
    tick();
    checks++;
    if (parity1 !== PAR_EN) $display("FAIL parity_hold: got %b want %b", parity1, PAR_EN);
    else passed++;
    checks++;
    if (word1 !== 4'b0111) $display("FAIL parity_word: got %b want 0111", word1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_dwell_timing();
    test_capture_isolation();
    test_reset_mid();
    test_back_to_back();
    test_parity();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
